gate_sequencer: RTL

- Parametrised power-gate sequencer for CH_NUM channels; next generation of the 5-channel startup stagger.
- Ramps gate enables up one channel at a time, LSB first. Each step waits a programmable delay and the matching per-channel sync/ack.
- New over the previous generation: controlled reverse-order ramp-down when start_i drops, a done/busy status, and an optional ack timeout with fault state.
- Sits between the control register block and the channel power switches.

---
 rtl/gate_sequencer.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/gate_sequencer.sv
// gate_sequencer: power-gate sequencer for CH_NUM channels.
// Ramps gate enables up one channel at a time (LSB first) while start_i is
// high and back down in reverse order when it drops. Each step waits for the
// delay counter to reach gate_shift_i and for gate_sync_i to mirror gate_en_o.
//
// Optional feature macro: GATE_SEQ_TIMEOUT_EN -- adds an ack-wait counter and
// a FAULT state entered after TIMEOUT_CYC mismatching wait cycles.
//
// Ports:
//   clk_i         system clock, posedge
//   rst_i         asynchronous active-high reset
//   start_i       level request: 1 = ramp up / hold on, 0 = ramp down / off
//   gate_sync_i   per-channel ack from the power switches
//   gate_shift_i  inter-step delay in cycles, sampled live
//   gate_en_o     registered gate enables (thermometer code)
//   busy_o        high while ramping up or down
//   done_o        high while all channels are on
//   fault_o       high in FAULT (constant 0 without the macro)
module gate_sequencer #(
  parameter int unsigned CH_NUM      = 5,
  parameter int unsigned CNT_WIDTH   = 32,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [CH_NUM-1:0]    gate_sync_i,
  input  logic [CNT_WIDTH-1:0] gate_shift_i,
  output logic [CH_NUM-1:0]    gate_en_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 fault_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RAMP_UP,
    ST_ON,
    ST_RAMP_DOWN
`ifdef GATE_SEQ_TIMEOUT_EN
    , ST_FAULT
`endif
  } state_e;

  state_e               state_q, state_d;
  logic [CH_NUM-1:0]    gate_en_q, gate_en_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 delay_met, sync_ok, step_ok, step;

`ifdef GATE_SEQ_TIMEOUT_EN
  localparam int unsigned WCNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              fault_q, fault_d;
  logic              timeout;
`endif

  assign delay_met = (cnt_q >= gate_shift_i);
  assign sync_ok   = (gate_sync_i == gate_en_q);
  assign step_ok   = delay_met && sync_ok;
`ifdef GATE_SEQ_TIMEOUT_EN
  assign timeout   = (wcnt_q == WCNT_W'(TIMEOUT_CYC));
`endif

  always_comb begin
    state_d   = state_q;
    gate_en_d = gate_en_q;
    step      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = ST_RAMP_UP;
      end
      ST_RAMP_UP: begin
        // A dropped request wins over a step due in the same cycle.
        if (!start_i) begin
          state_d = ST_RAMP_DOWN;
`ifdef GATE_SEQ_TIMEOUT_EN
        end else if (timeout) begin
          state_d   = ST_FAULT;
          gate_en_d = '0;
`endif
        end else if (step_ok) begin
          if (gate_en_q != '1) begin
            // Shift form keeps CH_NUM=1 legal (no [CH_NUM-2:0] slice).
            gate_en_d = (gate_en_q << 1) | CH_NUM'(1);
            step      = 1'b1;
          end else begin
            state_d = ST_ON;
          end
        end
      end
      ST_ON: begin
        if (!start_i) state_d = ST_RAMP_DOWN;
      end
      ST_RAMP_DOWN: begin
`ifdef GATE_SEQ_TIMEOUT_EN
        if (timeout) begin
          state_d   = ST_FAULT;
          gate_en_d = '0;
        end else
`endif
        if (step_ok) begin
          if (gate_en_q != '0) begin
            gate_en_d = gate_en_q >> 1;
            step      = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
`ifdef GATE_SEQ_TIMEOUT_EN
      ST_FAULT: begin
        if (!start_i) state_d = ST_IDLE;
      end
`endif
      default: begin
        state_d   = ST_IDLE;
        gate_en_d = '0;
      end
    endcase

    if ((state_d != state_q) || step) cnt_d = '0;
    else if (cnt_q == '1)             cnt_d = cnt_q;
    else                              cnt_d = cnt_q + CNT_WIDTH'(1);

`ifdef GATE_SEQ_TIMEOUT_EN
    if ((state_d != state_q) || step)
      wcnt_d = '0;
    else if ((state_q == ST_RAMP_UP || state_q == ST_RAMP_DOWN) && delay_met && !sync_ok)
      wcnt_d = wcnt_q + WCNT_W'(1);
    else
      wcnt_d = wcnt_q;
    fault_d = (state_d == ST_FAULT);
`endif

    busy_d = (state_d == ST_RAMP_UP) || (state_d == ST_RAMP_DOWN);
    done_d = (state_d == ST_ON);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      gate_en_q <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef GATE_SEQ_TIMEOUT_EN
      wcnt_q    <= '0;
      fault_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      gate_en_q <= gate_en_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef GATE_SEQ_TIMEOUT_EN
      wcnt_q    <= wcnt_d;
      fault_q   <= fault_d;
`endif
    end
  end

  assign gate_en_o = gate_en_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
`ifdef GATE_SEQ_TIMEOUT_EN
  assign fault_o   = fault_q;
`else
  assign fault_o   = 1'b0;
`endif

endmodule
